// File: rtl/ad9866_spi_responder_if.sv
// Purpose : groups the AD9866 SPI link pins and the host-side register/event outputs of the responder.
// Ports   : sclk/sen_n/sdio into the responder, sdo/sdo_oe back out, and write events, gain registers and frame_err toward the host.
// Modports: slave = the responder (codec side), master = whoever drives the SPI link and observes the host outputs.
interface ad9866_spi_responder_if;
    logic       sclk;
    logic       sen_n;
    logic       sdio;
    logic       sdo;
    logic       sdo_oe;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rx_gain_reg;
    logic [7:0] tx_gain_reg;
    logic       frame_err;

    modport slave (
        input  sclk, sen_n, sdio,
        output sdo, sdo_oe, wr_strobe, wr_addr, wr_data,
               rx_gain_reg, tx_gain_reg, frame_err
    );

    modport master (
        output sclk, sen_n, sdio,
        input  sdo, sdo_oe, wr_strobe, wr_addr, wr_data,
               rx_gain_reg, tx_gain_reg, frame_err
    );
endinterface

// File: rtl/ad9866_spi_responder.sv
// Purpose : AD9866-style 16-bit SPI configuration responder (R/W, 2-bit width, 5-bit addr, 8-bit data, MSB first) with a 32x8 register image.
// Latency : a write commits (wr_strobe, register image, gain outputs) SYNC_STAGES+1 clk after the physical 16th sclk rise.
// Backpressure: none; the SPI master owns timing and clk must run at least 8x sclk.
// Ports   : clk, reset (async, active-high); bus.slave carries sclk/sen_n/sdio in, sdo/sdo_oe out,
//           wr_strobe/wr_addr/wr_data write events, rx_gain_reg (reg 0x09), tx_gain_reg (reg 0x0a), frame_err.
module ad9866_spi_responder #(
    parameter int NREGS       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    ad9866_spi_responder_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    // ---------------------------------------------------------------
    // Input synchronizers; sdio is taken from the same stage as sclk so
    // the sampled data bit lines up with the detected rising edge.
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sen_sync_q;
    logic [SYNC_STAGES-1:0] sdio_sync_q;
    logic                   sclk_prev_q;
    logic                   sen_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            sen_sync_q  <= '1;   // idle-high so reset release cannot fake a frame start
            sdio_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            sen_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0],  bus.sen_n};
            sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], bus.sdio};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            sen_prev_q  <= sen_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, sen_s, sdio_s;
    logic sclk_rise, sclk_fall, sen_rise, sen_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sen_s     = sen_sync_q[SYNC_STAGES-1];
    assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign sen_rise  =  sen_s  & ~sen_prev_q;
    assign sen_fall  = ~sen_s  &  sen_prev_q;

    // ---------------------------------------------------------------
    // Frame state
    // ---------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [6:0]  shift_q,     shift_d;     // 7 held bits + incoming bit form each byte
    logic        rw_q,        rw_d;
    logic [4:0]  addr_q,      addr_d;
    logic [7:0]  rd_q,        rd_d;        // read byte, shifted out MSB first
    logic        sdo_q,       sdo_d;
    logic        sdo_oe_q,    sdo_oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [4:0]  wr_addr_q,   wr_addr_d;
    logic [7:0]  wr_data_q,   wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  regs_q [32];

    logic [7:0]  shift_nxt;
    logic [7:0]  lookup_dat;
    logic        frame_done;

    assign shift_nxt = {shift_q, sdio_s};

    // Read data is fetched at the instruction boundary; unimplemented addresses read as zero.
    always_comb begin
        lookup_dat = 8'h00;
        if ({1'b0, shift_nxt[4:0]} < NREGS_L) begin
            lookup_dat = regs_q[shift_nxt[4:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sdo_oe_d = 1'b0;
                sdo_d    = 1'b0;
                if (sen_fall) begin
                    state_d = ST_INSTR;
                    cnt_d   = 5'd0;
                    shift_d = '0;
                end
            end

            ST_INSTR: begin
                if (sclk_rise) begin
                    shift_d = shift_nxt[6:0];
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        // Width bits (14:13) are deliberately dropped.
                        rw_d    = shift_nxt[7];
                        addr_d  = shift_nxt[4:0];
                        rd_d    = lookup_dat;
                        state_d = ST_DATA;
                    end
                end
                if (sen_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    sdo_d       = 1'b0;
                    sdo_oe_d    = 1'b0;
                end
            end

            ST_DATA: begin
                if (sclk_rise) begin
                    shift_d = shift_nxt[6:0];
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d    = ST_WAIT;
                        frame_done = 1'b1;
                        if (!rw_q && ({1'b0, addr_q} < NREGS_L)) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = shift_nxt;
                        end
                    end
                end
                // Every fall in the data phase presents the next read bit,
                // the first one turning the driver on.
                if (sclk_fall && rw_q) begin
                    sdo_d    = rd_q[7];
                    rd_d     = {rd_q[6:0], 1'b0};
                    sdo_oe_d = 1'b1;
                end
                if (sen_rise) begin
                    state_d  = ST_IDLE;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                    // A rise landing with the 16th sclk edge still completes the frame.
                    frame_err_d = ~frame_done;
                end
            end

            ST_WAIT: begin
                if (sen_rise) begin
                    state_d  = ST_IDLE;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            rd_q        <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            // Image updates on the same edge as wr_strobe so the gain outputs track it.
            if (wr_strobe_d) begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign bus.sdo         = sdo_q;
    assign bus.sdo_oe      = sdo_oe_q;
    assign bus.wr_strobe   = wr_strobe_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.rx_gain_reg = regs_q[9];
    assign bus.tx_gain_reg = regs_q[10];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Purpose : directed + randomized frames against the responder, checked against a register-image model.
// Latency : frames are bit-banged at 16 clk per sclk period; results are checked after each frame closes.
// Backpressure: none; the bench is the SPI master.
module tb_ad9866_spi_responder;

    localparam int NREGS = 20;

    logic clk;
    logic reset;

    ad9866_spi_responder_if bus();

    ad9866_spi_responder #(.NREGS(NREGS), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Host-side event monitor
    int         n_strobe = 0;
    int         n_err    = 0;
    logic [4:0] last_addr;
    logic [7:0] last_data;
    logic [7:0] last_rx;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.wr_strobe) begin
                n_strobe  = n_strobe + 1;
                last_addr = bus.wr_addr;
                last_data = bus.wr_data;
                last_rx   = bus.rx_gain_reg;
            end
            if (bus.frame_err) n_err = n_err + 1;
        end
    end

    // Reference register image: a write to an implemented address stores the byte, everything else reads zero.
    logic [7:0] model [32];
    logic [7:0] rd_byte;
    logic       oe_pre, oe_post, oe_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_rd(input logic [4:0] a);
        return (int'(a) < NREGS) ? model[a] : 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit close);
        rd_byte = 8'h00;
        oe_pre  = 1'bx;
        oe_post = 1'bx;
        bus.sen_n = 1'b0;
        wait_clks(8);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) bus.sdio = word[15-i];
            else        bus.sdio = 1'b0;
            wait_clks(8);
            if (i == 7) oe_pre  = bus.sdo_oe;
            if (i == 8) oe_post = bus.sdo_oe;
            if (i >= 8 && i < 16) rd_byte = {rd_byte[6:0], bus.sdo};
            bus.sclk = 1'b1;
            wait_clks(8);
            bus.sclk = 1'b0;
        end
        wait_clks(8);
        oe_wait = bus.sdo_oe;
        if (close) begin
            bus.sen_n = 1'b1;
            wait_clks(8);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic [1:0] wb, input int nbits, input string tag);
        int s0 = n_strobe;
        int e0 = n_err;
        spi_frame({1'b0, wb, a, d}, nbits, 1'b1);
        if (int'(a) < NREGS) begin
            model[a] = d;
            chk({tag, " strobes"}, n_strobe - s0, 1);
            chk({tag, " wr_addr"}, last_addr, a);
            chk({tag, " wr_data"}, last_data, d);
        end else begin
            chk({tag, " strobes"}, n_strobe - s0, 0);
        end
        chk({tag, " frame_err"}, n_err - e0, 0);
        chk({tag, " rx_gain"}, bus.rx_gain_reg, model[9]);
        chk({tag, " tx_gain"}, bus.tx_gain_reg, model[10]);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [1:0] wb, input string tag);
        int s0 = n_strobe;
        spi_frame({1'b1, wb, a, 8'h00}, 16, 1'b1);
        chk({tag, " rdata"}, rd_byte, model_rd(a));
        chk({tag, " oe before bit8 fall"}, oe_pre, 1'b0);
        chk({tag, " oe after bit8 fall"}, oe_post, 1'b1);
        chk({tag, " oe in wait"}, oe_wait, 1'b1);
        chk({tag, " oe after sen_n"}, bus.sdo_oe, 1'b0);
        chk({tag, " strobes"}, n_strobe - s0, 0);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, e0;
        logic [4:0] ra;
        logic [7:0] rdat;
        logic [1:0] rwb;

        bus.sclk  = 1'b0;
        bus.sen_n = 1'b1;
        bus.sdio  = 1'b0;
        reset     = 1'b1;
        model_clear();
        wait_clks(4);
        #1;
        chk("reset sdo",       bus.sdo,         1'b0);
        chk("reset sdo_oe",    bus.sdo_oe,      1'b0);
        chk("reset wr_strobe", bus.wr_strobe,   1'b0);
        chk("reset wr_addr",   bus.wr_addr,     5'h00);
        chk("reset wr_data",   bus.wr_data,     8'h00);
        chk("reset frame_err", bus.frame_err,   1'b0);
        chk("reset rx_gain",   bus.rx_gain_reg, 8'h00);
        chk("reset tx_gain",   bus.tx_gain_reg, 8'h00);
        reset = 1'b0;
        wait_clks(6);

        // Gain register write: strobe and rx_gain output agree in the strobe cycle.
        do_write(5'h09, 8'h2A, 2'b00, 16, "wr 0x09");
        chk("rx_gain at strobe", last_rx, 8'h2A);

        // TX gain write then read-back over sdo.
        do_write(5'h0A, 8'h41, 2'b00, 16, "wr 0x0a");
        do_read(5'h0A, 2'b00, "rd 0x0a");

        // Unimplemented address: reads zero, writes ignored.
        do_read(5'h1F, 2'b00, "rd 0x1f");
        do_write(5'h1F, 8'hC3, 2'b00, 16, "wr 0x1f");
        do_read(5'h1F, 2'b00, "rd 0x1f again");
        do_write(5'h13, 8'h5A, 2'b00, 16, "wr last impl");
        do_write(5'h14, 8'hA5, 2'b00, 16, "wr first unimpl");
        do_read(5'h13, 2'b00, "rd last impl");
        do_read(5'h14, 2'b00, "rd first unimpl");

        // Abort after 11 bits.
        s0 = n_strobe;
        e0 = n_err;
        spi_frame(16'h0733, 11, 1'b1);
        chk("abort frame_err", n_err - e0, 1);
        chk("abort strobes",   n_strobe - s0, 0);
        do_read(5'h07, 2'b00, "rd 0x07 after abort");
        do_write(5'h07, 8'h21, 2'b00, 16, "wr 0x07");
        do_read(5'h07, 2'b00, "rd 0x07");

        // Over-long frame: extra sclk pulses are ignored.
        do_write(5'h04, 8'h55, 2'b00, 20, "wr 0x04 x20 clk");

        // Randomized frames, including the ignored width bits.
        for (int k = 0; k < 40; k++) begin
            ra   = 5'($urandom_range(0, 31));
            rdat = 8'($urandom);
            rwb  = 2'($urandom);
            if ($urandom_range(0, 1) == 1) do_read(ra, rwb, $sformatf("rand rd %0d", k));
            else                           do_write(ra, rdat, rwb, 16, $sformatf("rand wr %0d", k));
        end

        // Reset during a read's data phase.
        do_write(5'h0A, 8'h77, 2'b00, 16, "wr 0x0a pre-reset");
        spi_frame({1'b1, 2'b00, 5'h0A, 8'h00}, 12, 1'b0);
        reset = 1'b1;
        #1;
        chk("midreset sdo",     bus.sdo,         1'b0);
        chk("midreset sdo_oe",  bus.sdo_oe,      1'b0);
        chk("midreset rx_gain", bus.rx_gain_reg, 8'h00);
        chk("midreset tx_gain", bus.tx_gain_reg, 8'h00);
        model_clear();
        bus.sen_n = 1'b1;
        bus.sclk  = 1'b0;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(6);
        do_read(5'h07, 2'b00, "rd 0x07 after reset");
        do_write(5'h08, 8'h10, 2'b00, 16, "wr 0x08 after reset");
        do_read(5'h08, 2'b00, "rd 0x08 after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ad9866_spi_responder.md
Name: ad9866_spi_responder

Overview:
- SPI responder (slave) that implements the 4-wire, 16-bit AD9866 configuration protocol on the far side of the link: 1-bit R/W, 2-bit width field, 5-bit address, 8-bit data, MSB first.
- Used as a synthesizable codec-register model for loopback and bench verification of the FPGA's AD9866 configuration master.
- Also usable as a host-facing config port: holds a 32-entry x 8-bit register image and exposes write events plus the RX/TX gain registers.

Parameters:
- NREGS, 20, number of implemented registers (addresses 0..NREGS-1); max 32.
- SYNC_STAGES, 2, synchronizer depth for sclk, sen_n, sdio (min 2).

Ports:
- clk  in  1  system clock; must be at least 8x sclk frequency.
- reset  in  1  reset, asynchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to clk, idle low (mode 0).
- sen_n  in  1  active-low frame enable, asynchronous.
- sdio  in  1  serial data in, sampled on sclk rising edge.
- sdo  out  1  serial data out, changes after sclk falling edge.
- sdo_oe  out  1  high while a read data phase is driving sdo.
- wr_strobe  out  1  one-clk pulse when a write commits.
- wr_addr  out  5  address of the committed write; valid with wr_strobe.
- wr_data  out  8  data of the committed write; valid with wr_strobe.
- rx_gain_reg  out  8  live contents of register 0x09.
- tx_gain_reg  out  8  live contents of register 0x0a.
- frame_err  out  1  one-clk pulse when a frame aborts (sen_n high before bit 16).

Behaviour:
- Reset values: all registers 0x00; sdo=0, sdo_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_err=0; FSM=IDLE; bit counter=0.
- Synchronization: sclk, sen_n and sdio each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk by comparing with a 1-clk delayed copy. sdio is taken from the same synchronized stage as sclk.
- IDLE:
  - sdo_oe=0.
  - Synced sen_n falling -> INSTR, counter=0, shift register cleared.
  - sclk edges are ignored while sen_n is high.
- INSTR (bits 0..7):
  - Each sclk rise shifts sdio into the shift register (MSB first); counter increments.
  - After the 8th rise, latch rw=bit15, addr=bits12:8, then go to DATA.
  - Bits 14:13 are ignored.
- DATA, write (rw=0):
  - Each rise shifts in sdio. After the 16th rise, go to WAIT.
  - The same clk (registered, visible next clk): if addr<NREGS, reg[addr]<=data, wr_strobe=1, wr_addr=addr, wr_data=data.
  - If addr>=NREGS: no update, no strobe.
- DATA, read (rw=1):
  - The first sclk fall after the 8th rise sets sdo=reg[addr][7] and sdo_oe=1.
  - Each subsequent fall shifts out the next bit (bit6..bit0). Rises still count bits.
  - addr>=NREGS reads as 0x00.
  - After the 16th rise, go to WAIT. sdo_oe stays high until sen_n rises.
- WAIT: extra sclk edges are ignored (no streaming or auto-increment). Synced sen_n rise -> IDLE, sdo_oe=0, sdo=0.
- Abort: synced sen_n rises in INSTR or DATA with counter<16 -> frame_err pulse for 1 clk, no register update, -> IDLE.
- Same-clk sen_n rise and 16th sclk rise: the rise completes the frame (the write commits), then -> IDLE. No frame_err.
- Register-to-output latency: rx_gain_reg/tx_gain_reg reflect a write on the same clk wr_strobe is high.
- Write-to-frame latency: wr_strobe asserts SYNC_STAGES+1 clks after the physical 16th sclk rise.
- Reset mid-frame: immediate return to reset values, including the register image; the partial frame is discarded.

Test Plan:
- Write 0x0900 | 0x2A (addr 0x09, data 0x2A) -> single wr_strobe with wr_addr=0x09, wr_data=0x2A; rx_gain_reg=0x2A; no frame_err.
- Write addr 0x0a data 0x41, then read frame 0x8A00 -> sdo bits on clocks 9-16 = 0x41; sdo_oe high from the 8th fall until sen_n rises; tx_gain_reg=0x41.
- Read addr 0x1F with NREGS=20 -> sdo returns 0x00; write to 0x1F -> no wr_strobe, register image unchanged.
- Raise sen_n after 11 bits of write 0x0733 -> frame_err pulses once; reg 0x07 unchanged (0x00); next full write 0x0721 commits normally.
- Send 20 sclk pulses with sen_n low on write 0x0455 -> exactly one wr_strobe (0x04/0x55); extra bits ignored.
- Assert reset mid-read at bit 12 -> sdo=0, sdo_oe=0, all registers 0x00; following write 0x0810 succeeds.
